// File: rtl/ps2_pkg.sv
// Shared scan-code set 2 constants, event layout and parser state type
// for the PS/2 key event queue.
package ps2_pkg;

  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_BRK         = 8'hF0;
  localparam logic [7:0] SC_PAUSE       = 8'hE1;
  localparam logic [7:0] SC_BAT         = 8'hAA;
  localparam logic [7:0] SC_ACK         = 8'hFA;
  localparam logic [7:0] SC_RESEND      = 8'hFE;
  localparam logic [7:0] SC_ECHO        = 8'hEE;
  localparam logic [7:0] SC_ERR_LO      = 8'h00;
  localparam logic [7:0] SC_ERR_HI      = 8'hFF;
  localparam logic [7:0] SC_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] SC_FAKE_RSHIFT = 8'h59;
  localparam logic [7:0] SC_PAUSE_CODE  = 8'h77;

  // Bytes that follow E1 before the Pause sequence is complete.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int EVT_W           = 16;
  localparam int EVT_PRESSED_BIT = 15;
  localparam int EVT_EXT_BIT     = 8;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } ps2_state_e;

  function automatic logic [EVT_W-1:0] pack_evt(input logic pressed,
                                                input logic ext,
                                                input logic [7:0] code);
    logic [EVT_W-1:0] e;
    e                  = '0;
    e[EVT_PRESSED_BIT] = pressed;
    e[EVT_EXT_BIT]     = ext;
    e[7:0]             = code;
    return e;
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] code);
    return (code == SC_FAKE_LSHIFT) || (code == SC_FAKE_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Byte-stream input and event pop handshake of the PS/2 key event queue.
// master = system side (receiver + MMIO reader), slave = the queue.
interface ps2_key_event_queue_if;
  logic                       byte_valid;
  logic [7:0]                 byte_data;
  logic                       evt_valid;
  logic                       evt_ready;
  logic [ps2_pkg::EVT_W-1:0]  evt_data;

  modport master (output byte_valid, byte_data, evt_ready,
                  input  evt_valid, evt_data);
  modport slave  (input  byte_valid, byte_data, evt_ready,
                  output evt_valid, evt_data);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous FIFO with a registered head word (0 when empty).
// A push while full is accepted only if a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + PTR_W'(1);
  assign head    = head_q;
  assign count   = cnt;

  // Storage array; contents need no reset because the count gates them.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Next head word: next stored entry, a bypassed push into an emptying FIFO, or 0.
  always_comb begin
    head_d = head_q;
    if (pop_ok) begin
      if (cnt > CNT_W'(1)) head_d = mem[rd_nxt];
      else if (push_ok)    head_d = push_data;
      else                 head_d = '0;
    end else if (empty && push_ok) begin
      head_d = push_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
    end else begin
      head_q <= head_d;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code set 2 parser feeding a key event FIFO.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses repeated make
// events for a key that is still held.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  ps2_key_event_queue_if.slave bus,
  output logic [CNT_W-1:0]     evt_count,
  output logic                 overflow,
  input  logic                 overflow_clr
);
  ps2_state_e       state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             emit;
  logic [EVT_W-1:0] emit_evt;
  logic             suppress;
  logic             push, drop;
  logic             fifo_full, fifo_empty;

  // Parser state and Pause skip counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Parser next state and event emission; advances only on byte_valid.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    emit     = 1'b0;
    emit_evt = '0;
    if (bus.byte_valid) begin
      case (state_q)
        IDLE: begin
          case (bus.byte_data)
            SC_EXT:   state_d = EXT;
            SC_BRK:   state_d = BRK;
            SC_PAUSE: begin
              state_d = PAUSE;
              skip_d  = PAUSE_SKIP;
            end
            SC_BAT, SC_ACK, SC_RESEND, SC_ECHO, SC_ERR_LO, SC_ERR_HI: ;
            default: begin
              emit     = 1'b1;
              emit_evt = pack_evt(1'b1, 1'b0, bus.byte_data);
            end
          endcase
        end
        EXT: begin
          if (bus.byte_data == SC_BRK) begin
            state_d = EXT_BRK;
          end else begin
            state_d  = IDLE;
            emit     = !is_fake_shift(bus.byte_data);
            emit_evt = pack_evt(1'b1, 1'b1, bus.byte_data);
          end
        end
        BRK: begin
          state_d  = IDLE;
          emit     = 1'b1;
          emit_evt = pack_evt(1'b0, 1'b0, bus.byte_data);
        end
        EXT_BRK: begin
          state_d  = IDLE;
          emit     = !is_fake_shift(bus.byte_data);
          emit_evt = pack_evt(1'b0, 1'b1, bus.byte_data);
        end
        PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d  = IDLE;
            emit     = 1'b1;
            emit_evt = pack_evt(1'b1, 1'b1, SC_PAUSE_CODE);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_q;
  logic [8:0] key_q;

  // A make matching the still-held key is a typematic repeat.
  always_comb begin
    suppress = emit && emit_evt[EVT_PRESSED_BIT] && held_q &&
               (key_q == {emit_evt[EVT_EXT_BIT], emit_evt[7:0]});
  end

  // Track the last make pushed; its matching break releases it.
  always_ff @(posedge clock) begin
    if (reset) begin
      held_q <= 1'b0;
      key_q  <= '0;
    end else if (emit && !suppress) begin
      if (emit_evt[EVT_PRESSED_BIT]) begin
        held_q <= 1'b1;
        key_q  <= {emit_evt[EVT_EXT_BIT], emit_evt[7:0]};
      end else if (key_q == {emit_evt[EVT_EXT_BIT], emit_evt[7:0]}) begin
        held_q <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign push = emit && !suppress;
  assign drop = push && fifo_full && !(bus.evt_valid && bus.evt_ready);

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (emit_evt),
    .pop       (bus.evt_ready),
    .head      (bus.evt_data),
    .count     (evt_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.evt_valid = !fifo_empty;

  // Sticky overflow; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed scan-code sequences plus random
// byte traffic, all compared against a flag-based reference model.
module tb_ps2_key_event_queue;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             overflow_clr = 1'b0;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;

  ps2_key_event_queue_if bus();

  ps2_key_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .evt_count    (evt_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: prefix flags, Pause countdown, event queue, filter key.
  logic [15:0] mq[$];
  bit          m_ovf, m_ext, m_brk;
  int          m_pause;
  bit          f_held;
  logic [8:0]  f_key;

  function automatic void m_reset();
    mq.delete();
    m_ovf = 0; m_ext = 0; m_brk = 0; m_pause = 0;
    f_held = 0; f_key = '0;
  endfunction

  function automatic bit m_parse(input logic [7:0] b, output logic [15:0] e);
    bit fake;
    fake = (b == 8'h12) || (b == 8'h59);
    e = '0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin e = 16'h8177; return 1; end
      return 0;
    end
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_pause = 7;
      else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) ;
      else begin e = {8'h80, b}; return 1; end
      return 0;
    end
    if (m_ext && !m_brk && b == 8'hF0) begin m_brk = 1; return 0; end
    e = {!m_brk, 6'b0, m_ext, b};
    m_ext = 0; m_brk = 0;
    return !(e[8] && fake);
  endfunction

  function automatic void m_step(input bit bv, input logic [7:0] b, input bit rdy, input bit clr);
    bit emit, popv, drop;
    logic [15:0] e;
    emit = 0; e = '0;
    if (bv) emit = m_parse(b, e);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (emit) begin
      if (e[15]) begin
        if (f_held && f_key == {e[8], e[7:0]}) emit = 0;
        else begin f_held = 1; f_key = {e[8], e[7:0]}; end
      end else if (f_key == {e[8], e[7:0]}) f_held = 0;
    end
`endif
    popv = rdy && (mq.size() > 0);
    drop = emit && (mq.size() == DEPTH) && !popv;
    if (popv) void'(mq.pop_front());
    if (emit && !drop) mq.push_back(e);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endfunction

  task automatic cycle(input bit bv, input logic [7:0] b, input bit rdy, input bit clr);
    bus.byte_valid = bv;
    bus.byte_data  = b;
    bus.evt_ready  = rdy;
    overflow_clr   = clr;
    @(posedge clock);
    if (reset) m_reset();
    else m_step(bv, b, rdy, clr);
    #1;
    chk("evt_valid", bus.evt_valid, mq.size() > 0);
    chk("evt_data", bus.evt_data, mq.size() > 0 ? mq[0] : 16'h0);
    chk("evt_count", evt_count, mq.size());
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1, b, 0, 0);
    cycle(0, 8'h00, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && bus.evt_valid; i++) cycle(0, 8'h00, 1, 0);
    chk("drain_empty", bus.evt_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    reset = 1'b0;
  endtask

  logic [15:0] typ_exp[$];
  logic [7:0]  pool[12];

  initial begin
    bus.byte_valid = 0; bus.byte_data = 0; bus.evt_ready = 0;
    m_reset();
    do_reset();
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", bus.evt_data, 16'h0);

    // Single make, latency 1
    cycle(1, 8'h1C, 0, 0);
    chk("make_valid", bus.evt_valid, 1);
    chk("make_data", bus.evt_data, 16'h801C);
    chk("make_count", evt_count, 1);
    drain();

    send(8'hF0); chk("brk_prefix", evt_count, 0);
    send(8'h1C); chk("brk_data", bus.evt_data, 16'h001C); drain();
    send(8'hE0); chk("ext_prefix", evt_count, 0);
    send(8'h75); chk("ext_data", bus.evt_data, 16'h8175); drain();
    send(8'hE0); send(8'hF0); chk("extbrk_prefix", evt_count, 0);
    send(8'h75); chk("extbrk_data", bus.evt_data, 16'h0175); drain();

    // Fake shifts and control bytes
    foreach (pool[i]) pool[i] = 8'h00;
    send(8'hE0); send(8'h12); send(8'hE0); send(8'hF0); send(8'h12);
    send(8'hAA); send(8'hFA);
    chk("discard_count", evt_count, 0);
    send(8'h1C); chk("after_discard", bus.evt_data, 16'h801C); drain();

    // Pause sequence, back-to-back bytes
    cycle(1, 8'hE1, 0, 0); cycle(1, 8'h14, 0, 0); cycle(1, 8'h77, 0, 0);
    cycle(1, 8'hE1, 0, 0); cycle(1, 8'hF0, 0, 0); cycle(1, 8'h14, 0, 0);
    cycle(1, 8'hF0, 0, 0);
    chk("pause_pre", evt_count, 0);
    cycle(1, 8'h77, 0, 0);
    chk("pause_count", evt_count, 1);
    chk("pause_data", bus.evt_data, 16'h8177);
    cycle(0, 8'h00, 0, 0);
    drain();

    // Overflow
    for (int i = 1; i <= 17; i++) send(8'(i));
    chk("ovf_count", evt_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", bus.evt_data, 16'h8001);
    for (int i = 1; i <= 16; i++) begin
      chk("ovf_pop", bus.evt_data, 16'h8000 | i);
      cycle(0, 8'h00, 1, 0);
    end
    chk("ovf_empty", bus.evt_valid, 0);
    cycle(0, 8'h00, 0, 1);
    chk("ovf_clr", overflow, 0);

    // Typematic repeats
`ifdef PS2_TYPEMATIC_FILTER_EN
    typ_exp = '{16'h801C, 16'h001C, 16'h801C};
`else
    typ_exp = '{16'h801C, 16'h801C, 16'h801C, 16'h001C, 16'h801C};
`endif
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    chk("typ_count", evt_count, typ_exp.size());
    foreach (typ_exp[i]) begin
      chk("typ_pop", bus.evt_data, typ_exp[i]);
      cycle(0, 8'h00, 1, 0);
    end
    chk("typ_empty", bus.evt_valid, 0);

    // Reset mid-sequence
    send(8'hE0);
    do_reset();
    send(8'h75);
    chk("rst_prefix", bus.evt_data, 16'h8075);
    drain();

    // Random traffic
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h12, 8'h59, 8'h1C, 8'h75, 8'h14, 8'h77, 8'hFF, 8'h00};
    for (int n = 0; n < 4000; n++) begin
      bit bv, rdy, clr;
      logic [7:0] b;
      bv  = ($urandom_range(0, 2) == 0);
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      rdy = ((n / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 30) == 0);
      reset = ($urandom_range(0, 999) == 0);
      cycle(bv, b, rdy, clr);
    end
    reset = 1'b0;
    cycle(0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Sits directly downstream of the PS/2 byte receiver and consumes its stream of received scancode bytes.
- Parses scan-code set 2 sequences into key events:
  - E0 prefix marks an extended key.
  - F0 prefix marks a break (key release).
  - E1 introduces the Pause sequence.
- Completed events are buffered in a small FIFO.
- The keyboard MMIO register reads from this FIFO with a valid/ready pop handshake.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- byte_valid  input  1  one-cycle pulse: byte_data holds a newly received byte.
- byte_data  input  8  received scancode byte.
- evt_valid  output  1  FIFO non-empty; evt_data is valid.
- evt_ready  input  1  consumer pops the head entry when evt_valid && evt_ready.
- evt_data  output  16  head event:
  - bit15 = pressed (1 = make, 0 = break)
  - bit8 = extended
  - bits7:0 = code
  - all other bits 0
- evt_count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset:
  - Parser goes to IDLE; the FIFO is emptied.
  - evt_valid=0, evt_count=0, overflow=0, evt_data=0.
  - The filter register (see Optional Feature) is cleared.
  - Reset mid-sequence discards any partial prefix.
- Parser FSM advances only on cycles with byte_valid=1. Transitions:
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> PAUSE (skip counter = 7).
    - AA, FA, FE, EE, 00, FF are discarded and the FSM stays in IDLE.
    - Any other byte emits {pressed=1, ext=0, code}.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 or 59 (fake shift) are discarded -> IDLE.
    - Any other byte emits {1, 1, code} -> IDLE.
  - BRK: any byte emits {0, 0, code} -> IDLE.
  - EXT_BRK:
    - 12 or 59 are discarded -> IDLE.
    - Any other byte emits {0, 1, code} -> IDLE.
  - PAUSE:
    - Each byte decrements the skip counter.
    - When the 7th byte after E1 arrives, emit {1, 1, 8'h77} and go to IDLE.
    - Pause never produces a break event.
- Emit = push into the FIFO on the same clock edge that samples the completing byte. evt_valid goes high the cycle after that byte_valid when the FIFO was empty (latency 1).
- FIFO:
  - Head is registered; evt_data is stable while evt_valid=1 && evt_ready=0.
  - When empty, evt_data is 0.
  - Pointers are log2(DEPTH) bits and wrap naturally; count = writes − pops.
- Boundary conditions:
  - Push while full without a pop: the event is dropped, overflow<=1, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur, count is unchanged, no overflow.
  - Push and pop in the same cycle while not empty: count is unchanged.
  - Pop while empty: ignored.
  - overflow_clr and a new overflow in the same cycle: the set wins (overflow stays 1).
- byte_valid is never asserted on consecutive cycles by the receiver, but the block must still handle back-to-back pulses correctly, one byte per cycle.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A register holds {ext, code} and a held flag for the last make event pushed.
  - A make event that matches the register while held=1 is suppressed (not pushed, no overflow effect).
  - A break with a matching {ext, code} clears held.
  - Any other make event overwrites the register and sets held.
  - Reset clears held.
- Undefined: every typematic repeat make is pushed; the register logic is absent.

Decomposition:
- ps2_pkg holds:
  - scancode constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_RESEND=8'hFE, SC_ECHO=8'hEE, SC_FAKE_LSHIFT=8'h12, SC_FAKE_RSHIFT=8'h59.
  - EVT_W=16 and the event bit-position constants.
  - the parser state enum {IDLE, EXT, BRK, EXT_BRK, PAUSE}.
- One sub-module: ps2_evt_fifo, a generic synchronous FIFO (DEPTH, width 16, count, full/empty). The parser and filter live in the top module.

Test Plan:
- Byte 1C -> one event 16'h801C, evt_valid high 1 cycle later, evt_count=1.
- Bytes F0 1C -> 16'h001C; bytes E0 75 -> 16'h8175; bytes E0 F0 75 -> 16'h0175; no events emitted on the prefix bytes.
- Bytes E0 12 E0 F0 12, AA, FA -> no events, count stays 0; then 1C -> 16'h801C.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event 16'h8177, pushed on the 8th byte.
- 17 make events (codes 01..11) with evt_ready=0 -> count=16, overflow=1, head=16'h8001. Pop all -> codes 01..10 in order, then evt_valid=0. overflow_clr -> overflow=0.
- Bytes 1C 1C 1C F0 1C 1C:
  - with PS2_TYPEMATIC_FILTER_EN -> 801C, 001C, 801C.
  - without -> 801C ×3, 001C, 801C.
- Both cases also cover reset asserted after E0: the next byte 75 -> 16'h8075, confirming the partial prefix was discarded.
